word_guess_scanner: RTL and testbench
=====================================

// Module: word_guess_scanner
// PURPOSE
//  Read-side partner of the word-entry datapath. Player 1's word is stored in ram32x5, one 5-bit char per address, from address 0.
//  On each player-2 guess this block scans addresses 0..wordlength-1 through the RAM read port. It compares every char with the guess.
//  It keeps a per-position revealed mask, which the dash/letter renderer uses, and reports match/miss and remaining count to the game FSM.
// PARAMETERS
//  MAX_LEN  16  number of positions tracked in revealed[]; wordlength above this is clamped to MAX_LEN
// PORTS
//  clk            in   1        system clock, all state on posedge
//  resetn         in   1        reset, asynchronous, active-HIGH (port keeps codebase name)
//  new_word       in   1        1-cycle pulse: new word stored, clear revealed mask
//  wordlength     in   5        number of valid chars in RAM; sampled when a guess is accepted
//  guess_char     in   5        guessed char code (A=1..Z=26)
//  guess_valid    in   1        1-cycle request; accepted only when busy=0
//  ram_q          in   5        RAM read data, valid exactly 1 cycle after ram_addr
//  ram_addr       out  5        RAM read address (RAM wren held 0 by top level while busy)
//  busy           out  1        scan in progress
//  done           out  1        1-cycle pulse: result outputs updated this cycle
//  match          out  1        last guess equals >=1 position (revealed or not)
//  miss           out  1        1-cycle pulse with done when match=0 and wordlength!=0
//  hit_count      out  5        positions newly revealed by last guess
//  revealed       out  MAX_LEN  bit i=1: position i revealed; bits >= wordlength always 0
//  remaining      out  5        wordlength - popcount(revealed), updated with done
//  word_complete  out  1        level: remaining==0 and wordlength!=0, updated with done
// BEHAVIOUR
//  Reset (async, resetn=1): state IDLE; ram_addr=0, busy=0, done=0, match=0, miss=0.
//   Also on reset: hit_count=0, revealed=0, remaining=0, word_complete=0; an in-flight scan is abandoned, no done.
//  FSM states: IDLE, SCAN, LAST, REPORT.
//   IDLE: guess_valid=1 -> latch guess_char, latch len=min(wordlength,MAX_LEN), clear hit accumulator.
//    If len=0, go to REPORT. Otherwise set ram_addr=0, busy=1, go to SCAN.
//   SCAN: each cycle ram_addr increments. Data for addr k is compared in the cycle after addr k is presented.
//    When ram_addr=len-1 is presented, go to LAST.
//   LAST: compare the final char; ram_addr holds its value; go to REPORT.
//   REPORT: assert done; update match, miss, hit_count, remaining and word_complete; clear busy; go to IDLE.
//  Latency: guess accepted at cycle 0 -> done at cycle len+2; busy high for cycles 1..len+2.
//   For len=0, done comes at cycle 1 with match=0, miss=0, hit_count=0.
//  Compare at position k:
//   if ram_q==guess: set match accumulator.
//   if also revealed[k]==0: set revealed[k] and increment hit accumulator.
//   Repeated correct guess -> match=1, hit_count=0, miss=0.
//  guess_char=0 never matches; it is scanned normally (result: miss).
//  guess_valid while busy: ignored, no queueing.
//  new_word while busy: the scan completes normally. The mask is cleared the cycle after REPORT and remaining is updated then.
//  new_word in IDLE: revealed=0, remaining=wordlength, word_complete=0 on next cycle.
//  new_word together with guess_valid in IDLE: clear first, then accept the guess.
//  Arithmetic: hit accumulator and remaining are 5-bit; they cannot overflow because len<=MAX_LEN<=31.
//  done, miss: single-cycle pulses. match, hit_count, remaining and word_complete hold until the next done or new_word.
// TESTING
//  RAM={3,1,20} (C,A,T), wordlength=3, new_word, guess 1 at cycle 0 -> ram_addr 0,1,2 on cycles 1..3.
//   Result: done at cycle 5, match=1, hit_count=1, revealed=3'b010, remaining=2.
//  Same word, guess 1 again -> done, match=1, hit_count=0, miss=0, revealed unchanged.
//  Guess 5 -> done, match=0, miss=1 pulse, revealed/remaining unchanged.
//  RAM={1,1,1,2}, len 4, guess 1 then 2 -> hit_count 3 then 1; second done gives remaining=0, word_complete=1.
//  wordlength=0, guess 3 -> done at cycle 1, match=0, miss=0, busy=1 for 1 cycle.
//  Assert resetn at cycle 2 of a len-5 scan -> all outputs 0 at once, no done.
//   Guess_valid is ignored while busy; new_word mid-scan clears the mask after done.

Source files
------------

// File: rtl/word_guess_scanner.sv
// word_guess_scanner: scans the stored word for each guess, keeps the
// revealed mask, and reports match/miss/hit_count/remaining.
//
// Ports:
//   clk, resetn (async, active-high)
//   new_word            clears the revealed mask (deferred while busy)
//   wordlength          valid chars in RAM, clamped to MAX_LEN
//   guess_char/valid    guess request, taken only when idle
//   ram_q / ram_addr    RAM read port, one-cycle read latency
//   busy, done, match, miss, hit_count, revealed, remaining,
//   word_complete       results for the game FSM and the renderer
module word_guess_scanner #(
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               new_word,
  input  logic [4:0]         wordlength,
  input  logic [4:0]         guess_char,
  input  logic               guess_valid,
  input  logic [4:0]         ram_q,
  output logic [4:0]         ram_addr,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic               miss,
  output logic [4:0]         hit_count,
  output logic [MAX_LEN-1:0] revealed,
  output logic [4:0]         remaining,
  output logic               word_complete
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0] MAXL = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LAST,
    REPORT
  } state_t;

  state_t state, nstate;

  logic [4:0]         g;
  logic [4:0]         len;
  logic [4:0]         len_in;
  logic [MAX_LEN-1:0] lenmask;
  logic               cmp_valid;
  logic [IW-1:0]      cmp_pos;
  logic [4:0]         hit_acc;
  logic               match_acc;
  logic               pend;

  logic               accept;
  logic               eq;
  logic               newhit;
  logic [MAX_LEN-1:0] rev_nxt;
  logic [4:0]         hit_final;
  logic               match_final;
  logic [4:0]         rem_scan;
  logic               clr;

  function automatic logic [4:0] popc(input logic [MAX_LEN-1:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < MAX_LEN; i++)
      s = s + 5'(v[i]);
    return s;
  endfunction

  assign len_in = (wordlength > MAXL) ? MAXL : wordlength;
  assign accept = (state == IDLE) && guess_valid;
  assign busy   = (state != IDLE);
  assign done   = (state == REPORT);

  always_comb begin
    lenmask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      lenmask[i] = (5'(i) < len_in);
  end

  // Code 0 is "no char" and must never count as a match.
  assign eq          = cmp_valid && (ram_q == g) && (g != 5'd0);
  assign newhit      = eq && !revealed[cmp_pos];
  assign rev_nxt     = revealed | (MAX_LEN'(newhit) << cmp_pos);
  assign hit_final   = hit_acc + 5'(newhit);
  assign match_final = match_acc | eq;
  assign rem_scan    = len - popc(rev_nxt);

  // A new_word seen while busy is held until the scan has reported.
  assign clr = (new_word && state == IDLE) ||
               (state == REPORT && (pend || new_word));

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (guess_valid)
          nstate = (len_in == 5'd0) ? REPORT : SCAN;
      SCAN:
        if (ram_addr == len - 5'd1)
          nstate = LAST;
      LAST:    nstate = REPORT;
      REPORT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      g         <= '0;
      len       <= '0;
      ram_addr  <= '0;
      cmp_valid <= 1'b0;
      cmp_pos   <= '0;
      hit_acc   <= '0;
      match_acc <= 1'b0;
      pend      <= 1'b0;
    end else begin
      // Data for the address presented now arrives next cycle.
      cmp_valid <= (state == SCAN);
      cmp_pos   <= ram_addr[IW-1:0];
      if (accept) begin
        g         <= guess_char;
        len       <= len_in;
        ram_addr  <= '0;
        hit_acc   <= '0;
        match_acc <= 1'b0;
      end else begin
        if (state == SCAN && nstate == SCAN)
          ram_addr <= ram_addr + 5'd1;
        if (cmp_valid) begin
          hit_acc   <= hit_final;
          match_acc <= match_final;
        end
      end
      if (state == IDLE || state == REPORT) pend <= 1'b0;
      else if (new_word)                    pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      match         <= 1'b0;
      miss          <= 1'b0;
      hit_count     <= '0;
      revealed      <= '0;
      remaining     <= '0;
      word_complete <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (clr)            revealed <= '0;
      else if (accept)    revealed <= revealed & lenmask;
      else if (cmp_valid) revealed <= rev_nxt;
      if (clr) begin
        remaining     <= len_in;
        word_complete <= 1'b0;
      end
      if (state == LAST) begin
        match         <= match_final;
        miss          <= !match_final;
        hit_count     <= hit_final;
        remaining     <= rem_scan;
        word_complete <= (rem_scan == 5'd0);
      end else if (accept && len_in == 5'd0) begin
        match         <= 1'b0;
        hit_count     <= '0;
        remaining     <= '0;
        word_complete <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_guess_scanner.sv
// Directed testbench for word_guess_scanner with a behavioural
// one-cycle-latency RAM model.
module tb_word_guess_scanner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        new_word;
  logic [4:0]  wordlength;
  logic [4:0]  guess_char;
  logic        guess_valid;
  logic [4:0]  ram_q;
  logic [4:0]  ram_addr;
  logic        busy;
  logic        done;
  logic        match;
  logic        miss;
  logic [4:0]  hit_count;
  logic [15:0] revealed;
  logic [4:0]  remaining;
  logic        word_complete;

  logic [4:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  word_guess_scanner #(.MAX_LEN(16)) dut (
    .clk(clk), .resetn(resetn), .new_word(new_word),
    .wordlength(wordlength), .guess_char(guess_char),
    .guess_valid(guess_valid), .ram_q(ram_q), .ram_addr(ram_addr),
    .busy(busy), .done(done), .match(match), .miss(miss),
    .hit_count(hit_count), .revealed(revealed),
    .remaining(remaining), .word_complete(word_complete)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_word();
    new_word = 1'b1;
    tick();
    new_word = 1'b0;
  endtask

  task automatic run_guess(input logic [4:0] ch, output int cyc);
    guess_char  = ch;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got done=%0b after %0d cycles, want 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; new_word = 1'b0; wordlength = 5'd0;
    guess_char = 5'd0; guess_valid = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 5'd0;
    tick(); tick();
    checks++;
    if ({busy, done, match, miss, ram_addr, hit_count, remaining, word_complete} !== 20'd0 ||
        revealed !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b match=%0b miss=%0b addr=%0d hit=%0d rem=%0d wc=%0b rev=%h, want all 0",
               busy, done, match, miss, ram_addr, hit_count, remaining, word_complete, revealed);
    end
    resetn = 1'b0;
    tick();
  endtask

  task automatic test_first_guess();
    int cyc;
    mem[0] = 5'd3; mem[1] = 5'd1; mem[2] = 5'd20;
    wordlength = 5'd3;
    pulse_new_word();
    checks++;
    if (remaining !== 5'd3) begin
      errors++;
      $display("FAIL new_word_remaining: got %0d want 3", remaining);
    end
    guess_char = 5'd1; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (ram_addr !== 5'(c - 1) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL scan_addr c%0d: got addr=%0d busy=%0b done=%0b want addr=%0d busy=1 done=0",
                 c, ram_addr, busy, done, c - 1);
      end
      tick();
    end
    cyc = 4;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL done_latency: got cycle %0d want 5", cyc);
    end
    checks++;
    if (match !== 1'b1 || hit_count !== 5'd1 || revealed !== 16'h0002 ||
        remaining !== 5'd2 || miss !== 1'b0 || word_complete !== 1'b0) begin
      errors++;
      $display("FAIL cat_guess_a: got m=%0b hit=%0d rev=%h rem=%0d miss=%0b wc=%0b want 1 1 0002 2 0 0",
               match, hit_count, revealed, remaining, miss, word_complete);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%0b busy=%0b want 0 0", done, busy);
    end
  endtask

  task automatic test_repeat_and_miss();
    int cyc;
    run_guess(5'd1, cyc);
    checks++;
    if (match !== 1'b1 || hit_count !== 5'd0 || miss !== 1'b0 || revealed !== 16'h0002) begin
      errors++;
      $display("FAIL repeat_guess: got m=%0b hit=%0d miss=%0b rev=%h want 1 0 0 0002",
               match, hit_count, miss, revealed);
    end
    tick();
    run_guess(5'd5, cyc);
    checks++;
    if (match !== 1'b0 || miss !== 1'b1 || revealed !== 16'h0002 || remaining !== 5'd2) begin
      errors++;
      $display("FAIL miss_guess: got m=%0b miss=%0b rev=%h rem=%0d want 0 1 0002 2",
               match, miss, revealed, remaining);
    end
    tick();
    checks++;
    if (miss !== 1'b0) begin
      errors++;
      $display("FAIL miss_pulse: got %0b want 0", miss);
    end
  endtask

  task automatic test_multi_hit();
    int cyc;
    mem[0] = 5'd1; mem[1] = 5'd1; mem[2] = 5'd1; mem[3] = 5'd2;
    wordlength = 5'd4;
    pulse_new_word();
    run_guess(5'd1, cyc);
    checks++;
    if (hit_count !== 5'd3 || revealed !== 16'h0007 || remaining !== 5'd1 ||
        word_complete !== 1'b0 || cyc !== 6) begin
      errors++;
      $display("FAIL multi_a: got hit=%0d rev=%h rem=%0d wc=%0b cyc=%0d want 3 0007 1 0 6",
               hit_count, revealed, remaining, word_complete, cyc);
    end
    tick();
    run_guess(5'd2, cyc);
    checks++;
    if (hit_count !== 5'd1 || revealed !== 16'h000f || remaining !== 5'd0 ||
        word_complete !== 1'b1 || match !== 1'b1) begin
      errors++;
      $display("FAIL multi_b: got hit=%0d rev=%h rem=%0d wc=%0b m=%0b want 1 000f 0 1 1",
               hit_count, revealed, remaining, word_complete, match);
    end
    tick();
  endtask

  task automatic test_guess_zero();
    int cyc;
    mem[0] = 5'd0; mem[1] = 5'd0; mem[2] = 5'd0;
    wordlength = 5'd3;
    pulse_new_word();
    run_guess(5'd0, cyc);
    checks++;
    if (match !== 1'b0 || miss !== 1'b1 || hit_count !== 5'd0 || revealed !== 16'h0000) begin
      errors++;
      $display("FAIL guess_zero: got m=%0b miss=%0b hit=%0d rev=%h want 0 1 0 0000",
               match, miss, hit_count, revealed);
    end
    tick();
  endtask

  task automatic test_clamp();
    int cyc;
    for (int i = 0; i < 32; i++) mem[i] = (i >= 15) ? 5'd7 : 5'd9;
    wordlength = 5'd20;
    pulse_new_word();
    checks++;
    if (remaining !== 5'd16) begin
      errors++;
      $display("FAIL clamp_remaining: got %0d want 16", remaining);
    end
    run_guess(5'd7, cyc);
    checks++;
    if (cyc !== 18 || hit_count !== 5'd1 || revealed !== 16'h8000 || remaining !== 5'd15) begin
      errors++;
      $display("FAIL clamp_scan: got cyc=%0d hit=%0d rev=%h rem=%0d want 18 1 8000 15",
               cyc, hit_count, revealed, remaining);
    end
    tick();
  endtask

  task automatic test_zero_len();
    wordlength = 5'd0;
    guess_char = 5'd3; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || match !== 1'b0 || miss !== 1'b0 || hit_count !== 5'd0) begin
      errors++;
      $display("FAIL zero_len: got done=%0b busy=%0b m=%0b miss=%0b hit=%0d want 1 1 0 0 0",
               done, busy, match, miss, hit_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_end: got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    mem[0] = 5'd3; mem[1] = 5'd1; mem[2] = 5'd20;
    wordlength = 5'd3;
    pulse_new_word();
    guess_char = 5'd1; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    guess_char = 5'd3; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0; new_word = 1'b1;
    tick();
    new_word = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || match !== 1'b1 || hit_count !== 5'd1 ||
        revealed !== 16'h0002 || remaining !== 5'd2) begin
      errors++;
      $display("FAIL busy_ignore: got done=%0b m=%0b hit=%0d rev=%h rem=%0d want 1 1 1 0002 2",
               done, match, hit_count, revealed, remaining);
    end
    tick();
    checks++;
    if (revealed !== 16'h0000 || remaining !== 5'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL deferred_clear: got rev=%h rem=%0d busy=%0b want 0000 3 0",
               revealed, remaining, busy);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL no_queue: got %0d extra dones want 0", extra);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    for (int i = 0; i < 5; i++) mem[i] = 5'(i + 1);
    wordlength = 5'd5;
    pulse_new_word();
    guess_char = 5'd2; guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_addr !== 5'd0 ||
        remaining !== 5'd0 || revealed !== 16'h0000 || match !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%0b done=%0b addr=%0d rem=%0d rev=%h m=%0b want all 0",
               busy, done, ram_addr, remaining, revealed, match);
    end
    tick();
    resetn = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abandon: got %0d busy/done cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_first_guess();
    test_repeat_and_miss();
    test_multi_hit();
    test_guess_zero();
    test_clamp();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
